strum_key_decoder: RTL and testbench

Turns raw PS/2 scan bytes from `ps2_rx` into lane-level key state and press events for the note-lane game. It sits between `ps2_rx` (upstream) and the game/scoring logic beside the VGA controller (downstream). Internally it strips the `F0` break prefix and the `E0` extended prefix, filters typematic auto-repeat, and queues one event per fresh key press in a small FIFO with a valid/ready handshake.

---
 rtl/strum_key_decoder_pkg.sv | 31 +++
 rtl/key_event_fifo.sv | 84 ++++++++
 rtl/strum_key_decoder.sv | 161 ++++++++++++++++
 tb/tb_strum_key_decoder.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/strum_key_decoder_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : strum_pkg
//  Purpose  : Shared PS/2 constants, default lane codes, lane type and the
//             prefix-decoder state encoding for the note-lane key decoder.
//  Revision : 1.0 - initial release
// ============================================================================
package strum_pkg;

    // PS/2 set-2 prefix bytes
    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    // Default make codes for the four lanes (A, S, D, F)
    localparam logic [7:0] LANE0_DEFAULT = 8'h1C;
    localparam logic [7:0] LANE1_DEFAULT = 8'h1B;
    localparam logic [7:0] LANE2_DEFAULT = 8'h23;
    localparam logic [7:0] LANE3_DEFAULT = 8'h2B;

    typedef logic [1:0] lane_t;

    // Prefix decoder states; the width is fixed at two bits
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BRK     = 2'd1,
        EXT     = 2'd2,
        EXT_BRK = 2'd3
    } dec_state_t;

endpackage : strum_pkg
`default_nettype wire

// File: rtl/key_event_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : key_event_fifo
//  Purpose  : Generic synchronous FIFO. A push into a full FIFO is dropped and
//             reported on a one-cycle drop strobe unless a pop happens in the
//             same cycle, in which case both succeed. Read data is taken from
//             the registered read pointer, so it holds steady until popped.
//  Revision : 1.0 - initial release
// ============================================================================
module key_event_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     drop_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;

    logic             do_push;
    logic             do_pop;
    logic             full_w;
    logic             empty_w;

    assign full_w  = (count_q == FULL_COUNT);
    assign empty_w = (count_q == '0);

    // Qualify the handshake: pops only from a non-empty FIFO, pushes only
    // when a slot is free or is being freed by a same-cycle pop.
    always_comb begin
        do_pop  = pop_i && !empty_w;
        do_push = push_i && (!full_w || do_pop);
        drop_o  = push_i && full_w && !do_pop;
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage, pointers and occupancy; power-of-two depth lets pointers wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = full_w;
    assign empty_o = empty_w;
    assign count_o = count_q;

endmodule : key_event_fifo
`default_nettype wire

// File: rtl/strum_key_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : strum_key_decoder
//  Purpose  : Converts PS/2 scan bytes into per-lane held state and a queue
//             of fresh key-press events. Strips F0/E0 prefixes, ignores all
//             extended keys, and suppresses typematic repeats.
//  Revision : 1.0 - initial release
// ============================================================================
module strum_key_decoder
    import strum_pkg::*;
#(
    parameter int         DEPTH      = 4,
    parameter logic [7:0] LANE0_CODE = LANE0_DEFAULT,
    parameter logic [7:0] LANE1_CODE = LANE1_DEFAULT,
    parameter logic [7:0] LANE2_CODE = LANE2_DEFAULT,
    parameter logic [7:0] LANE3_CODE = LANE3_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     scan_done_tick,
    input  logic [7:0]               scan_code,
    output logic [3:0]               lane_held,
    output logic                     ev_valid,
    output logic [1:0]               ev_lane,
    input  logic                     ev_ready,
    output logic [$clog2(DEPTH):0]   ev_count,
    output logic                     overflow
);

    dec_state_t state_q;
    dec_state_t state_d;

    logic [3:0] lane_held_q;
    logic [3:0] lane_held_d;
    logic       overflow_q;

    logic       is_make;
    logic       is_break;
    logic       lane_hit;
    lane_t      lane_sel;
    logic       push;
    logic       fifo_drop;
    logic       fifo_full;
    logic       fifo_empty;
    lane_t      fifo_head;

    // Prefix state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Prefix next-state: advances only on a received byte
    always_comb begin
        state_d = state_q;
        if (scan_done_tick) begin
            case (state_q)
                IDLE: begin
                    if (scan_code == PS2_BREAK) begin
                        state_d = BRK;
                    end else if (scan_code == PS2_EXT) begin
                        state_d = EXT;
                    end else begin
                        state_d = IDLE;
                    end
                end
                BRK:     state_d = IDLE;
                EXT:     state_d = (scan_code == PS2_BREAK) ? EXT_BRK : IDLE;
                EXT_BRK: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Byte classification; extended makes/breaks never qualify
    always_comb begin
        is_make  = 1'b0;
        is_break = 1'b0;
        if (scan_done_tick) begin
            case (state_q)
                IDLE:    is_make  = (scan_code != PS2_BREAK) && (scan_code != PS2_EXT);
                BRK:     is_break = 1'b1;
                default: begin
                    is_make  = 1'b0;
                    is_break = 1'b0;
                end
            endcase
        end
    end

    // Map the byte onto a lane; a second F0 in BRK simply misses here
    always_comb begin
        lane_hit = 1'b1;
        lane_sel = 2'd0;
        if (scan_code == LANE0_CODE) begin
            lane_sel = 2'd0;
        end else if (scan_code == LANE1_CODE) begin
            lane_sel = 2'd1;
        end else if (scan_code == LANE2_CODE) begin
            lane_sel = 2'd2;
        end else if (scan_code == LANE3_CODE) begin
            lane_sel = 2'd3;
        end else begin
            lane_hit = 1'b0;
        end
    end

    // Held-state update; a make on an already-held lane is a typematic repeat
    always_comb begin
        lane_held_d = lane_held_q;
        push        = 1'b0;
        if (is_make && lane_hit && !lane_held_q[lane_sel]) begin
            lane_held_d[lane_sel] = 1'b1;
            push                  = 1'b1;
        end
        if (is_break && lane_hit) begin
            lane_held_d[lane_sel] = 1'b0;
        end
    end

    // Held lanes and the sticky overflow flag
    always_ff @(posedge clk) begin
        if (reset) begin
            lane_held_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            lane_held_q <= lane_held_d;
            overflow_q  <= overflow_q | fifo_drop;
        end
    end

    key_event_fifo #(
        .WIDTH (2),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .data_i  (lane_sel),
        .pop_i   (ev_ready),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (ev_count),
        .drop_o  (fifo_drop)
    );

    assign lane_held = lane_held_q;
    assign ev_valid  = !fifo_empty;
    assign ev_lane   = fifo_head;
    assign overflow  = overflow_q;

    // Full flag is not needed outside the FIFO; fold it in to keep it consumed
    logic unused_full;
    assign unused_full = fifo_full;

endmodule : strum_key_decoder
`default_nettype wire

// File: tb/tb_strum_key_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_strum_key_decoder
//  Purpose  : Directed, table-driven bench for strum_key_decoder with a few
//             hand-written multi-cycle sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_strum_key_decoder;

    logic       clk;
    logic       reset;
    logic       scan_done_tick;
    logic [7:0] scan_code;
    logic [3:0] lane_held;
    logic       ev_valid;
    logic [1:0] ev_lane;
    logic       ev_ready;
    logic [2:0] ev_count;
    logic       overflow;

    int total;
    int bad;

    strum_key_decoder #(.DEPTH(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .scan_done_tick (scan_done_tick),
        .scan_code      (scan_code),
        .lane_held      (lane_held),
        .ev_valid       (ev_valid),
        .ev_lane        (ev_lane),
        .ev_ready       (ev_ready),
        .ev_count       (ev_count),
        .overflow       (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       tick;
        logic [7:0] code;
        logic       ready;
        logic [3:0] held;
        logic       valid;
        logic [1:0] lane;
        logic [2:0] cnt;
        logic       ovf;
    } vec_t;

    vec_t vt[$];

    function automatic void add(input logic t, input logic [7:0] c, input logic r,
                                input logic [3:0] h, input logic v, input logic [1:0] l,
                                input logic [2:0] n, input logic o);
        vec_t e;
        e.tick = t; e.code = c; e.ready = r;
        e.held = h; e.valid = v; e.lane = l; e.cnt = n; e.ovf = o;
        vt.push_back(e);
    endfunction

    task automatic step(input logic r, input logic t, input logic [7:0] c, input logic rd);
        reset          = r;
        scan_done_tick = t;
        scan_code      = c;
        ev_ready       = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] h, input logic v,
                       input logic [1:0] l, input logic chk_lane,
                       input logic [2:0] n, input logic o);
        cmp({tag, ".held"},  int'(lane_held), int'(h));
        cmp({tag, ".valid"}, int'(ev_valid),  int'(v));
        if (chk_lane) cmp({tag, ".lane"}, int'(ev_lane), int'(l));
        cmp({tag, ".count"}, int'(ev_count),  int'(n));
        cmp({tag, ".ovf"},   int'(overflow),  int'(o));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1; scan_done_tick = 1'b0; scan_code = 8'h00; ev_ready = 1'b0;

        // ---------------- vector table ----------------
        // single press, consumer ready: valid next cycle, drops the cycle after
        add(1, 8'h1C, 1, 4'b0001, 1, 2'd0, 3'd1, 0);
        add(0, 8'h00, 1, 4'b0001, 0, 2'd0, 3'd0, 0);
        add(1, 8'hF0, 1, 4'b0001, 0, 2'd0, 3'd0, 0);
        add(1, 8'h1C, 1, 4'b0000, 0, 2'd0, 3'd0, 0);
        // typematic repeat of lane 1 then release
        add(1, 8'h1B, 0, 4'b0010, 1, 2'd1, 3'd1, 0);
        add(1, 8'h1B, 0, 4'b0010, 1, 2'd1, 3'd1, 0);
        add(1, 8'h1B, 0, 4'b0010, 1, 2'd1, 3'd1, 0);
        add(1, 8'hF0, 0, 4'b0010, 1, 2'd1, 3'd1, 0);
        add(1, 8'h1B, 0, 4'b0000, 1, 2'd1, 3'd1, 0);
        add(0, 8'h00, 1, 4'b0000, 0, 2'd0, 3'd0, 0);
        // extended make/break ignored, FSM returns to IDLE
        add(1, 8'hE0, 0, 4'b0000, 0, 2'd0, 3'd0, 0);
        add(1, 8'h1C, 0, 4'b0000, 0, 2'd0, 3'd0, 0);
        add(1, 8'hE0, 0, 4'b0000, 0, 2'd0, 3'd0, 0);
        add(1, 8'hF0, 0, 4'b0000, 0, 2'd0, 3'd0, 0);
        add(1, 8'h1C, 0, 4'b0000, 0, 2'd0, 3'd0, 0);
        add(1, 8'h23, 0, 4'b0100, 1, 2'd2, 3'd1, 0);
        add(1, 8'hF0, 1, 4'b0100, 0, 2'd0, 3'd0, 0);
        add(1, 8'h23, 1, 4'b0000, 0, 2'd0, 3'd0, 0);
        // non-lane bytes change nothing
        add(1, 8'hAA, 0, 4'b0000, 0, 2'd0, 3'd0, 0);
        add(1, 8'hFA, 0, 4'b0000, 0, 2'd0, 3'd0, 0);
        // F0 F0 in BRK is a no-op break, then 1C is a make again
        add(1, 8'hF0, 0, 4'b0000, 0, 2'd0, 3'd0, 0);
        add(1, 8'hF0, 0, 4'b0000, 0, 2'd0, 3'd0, 0);
        add(1, 8'h1C, 1, 4'b0001, 1, 2'd0, 3'd1, 0);
        add(1, 8'hF0, 1, 4'b0001, 0, 2'd0, 3'd0, 0);
        add(1, 8'h1C, 0, 4'b0000, 0, 2'd0, 3'd0, 0);
        // five presses with consumer stalled: overflow, drain in order
        add(1, 8'h1C, 0, 4'b0001, 1, 2'd0, 3'd1, 0);
        add(1, 8'hF0, 0, 4'b0001, 1, 2'd0, 3'd1, 0);
        add(1, 8'h1C, 0, 4'b0000, 1, 2'd0, 3'd1, 0);
        add(1, 8'h1B, 0, 4'b0010, 1, 2'd0, 3'd2, 0);
        add(1, 8'hF0, 0, 4'b0010, 1, 2'd0, 3'd2, 0);
        add(1, 8'h1B, 0, 4'b0000, 1, 2'd0, 3'd2, 0);
        add(1, 8'h23, 0, 4'b0100, 1, 2'd0, 3'd3, 0);
        add(1, 8'hF0, 0, 4'b0100, 1, 2'd0, 3'd3, 0);
        add(1, 8'h23, 0, 4'b0000, 1, 2'd0, 3'd3, 0);
        add(1, 8'h2B, 0, 4'b1000, 1, 2'd0, 3'd4, 0);
        add(1, 8'hF0, 0, 4'b1000, 1, 2'd0, 3'd4, 0);
        add(1, 8'h2B, 0, 4'b0000, 1, 2'd0, 3'd4, 0);
        add(1, 8'h1C, 0, 4'b0001, 1, 2'd0, 3'd4, 1);
        add(1, 8'hF0, 0, 4'b0001, 1, 2'd0, 3'd4, 1);
        add(1, 8'h1C, 0, 4'b0000, 1, 2'd0, 3'd4, 1);
        add(0, 8'h00, 1, 4'b0000, 1, 2'd1, 3'd3, 1);
        add(0, 8'h00, 1, 4'b0000, 1, 2'd2, 3'd2, 1);
        add(0, 8'h00, 1, 4'b0000, 1, 2'd3, 3'd1, 1);
        add(0, 8'h00, 1, 4'b0000, 0, 2'd0, 3'd0, 1);

        // ---------------- reset state ----------------
        step(1, 0, 8'h00, 0);
        step(1, 0, 8'h00, 0);
        chk("reset", 4'b0000, 0, 2'd0, 1, 3'd0, 0);

        // ---------------- apply table ----------------
        for (int i = 0; i < vt.size(); i++) begin
            step(0, vt[i].tick, vt[i].code, vt[i].ready);
            chk($sformatf("vec%0d", i), vt[i].held, vt[i].valid, vt[i].lane,
                vt[i].valid, vt[i].cnt, vt[i].ovf);
        end

        // ---------------- full FIFO: simultaneous push and pop ----------------
        step(1, 0, 8'h00, 0);
        chk("rst2", 4'b0000, 0, 2'd0, 1, 3'd0, 0);
        step(0, 1, 8'h1C, 0);
        step(0, 1, 8'h1B, 0);
        step(0, 1, 8'h23, 0);
        step(0, 1, 8'h2B, 0);
        chk("fill", 4'b1111, 1, 2'd0, 1, 3'd4, 0);
        step(0, 1, 8'hF0, 0);
        step(0, 1, 8'h1C, 0);
        chk("rel0", 4'b1110, 1, 2'd0, 1, 3'd4, 0);
        step(0, 1, 8'h1C, 1);
        chk("pushpop", 4'b1111, 1, 2'd1, 1, 3'd4, 0);
        step(0, 0, 8'h00, 1);
        chk("pp_dr1", 4'b1111, 1, 2'd2, 1, 3'd3, 0);
        step(0, 0, 8'h00, 1);
        chk("pp_dr2", 4'b1111, 1, 2'd3, 1, 3'd2, 0);
        step(0, 0, 8'h00, 1);
        chk("pp_dr3", 4'b1111, 1, 2'd0, 1, 3'd1, 0);
        step(0, 0, 8'h00, 1);
        chk("pp_dr4", 4'b1111, 0, 2'd0, 0, 3'd0, 0);

        // ---------------- reset mid-sequence after F0 ----------------
        step(0, 1, 8'hF0, 0);
        step(1, 0, 8'h00, 0);
        chk("midrst", 4'b0000, 0, 2'd0, 1, 3'd0, 0);
        step(0, 1, 8'h1C, 0);
        chk("postrst", 4'b0001, 1, 2'd0, 1, 3'd1, 0);

        // ---------------- reset mid-sequence after E0 ----------------
        step(0, 1, 8'hE0, 0);
        step(1, 0, 8'h00, 0);
        step(0, 1, 8'h1B, 0);
        chk("postrst_e0", 4'b0010, 1, 2'd1, 1, 3'd1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_strum_key_decoder
`default_nettype wire
